light_pattern_gen: RTL



---
 rtl/light_pkg.sv | 8 +
 rtl/tick_prescaler.sv | 20 ++
 rtl/light_pattern_gen.sv | 81 ++++++++
 3 files changed

// File: rtl/light_pkg.sv
// light_pkg: shared mode and direction encodings for the light pattern blocks
package light_pkg;
   localparam logic [1:0] MODE_HOLD   = 2'b00;
   localparam logic [1:0] MODE_ROT_L  = 2'b01;
   localparam logic [1:0] MODE_ROT_R  = 2'b10;
   localparam logic [1:0] MODE_BOUNCE = 2'b11;
   typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides enabled clk cycles into a one-cycle step strobe every TICK_DIV cycles
module tick_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic step
);
   localparam int CNT_W = $clog2(TICK_DIV) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
   logic [CNT_W-1:0] cnt;
   assign step = enable && (cnt == LAST);
   // count enabled cycles, restarting on clear or after the last count
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable) cnt <= step ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/light_pattern_gen.sv
// light_pattern_gen: WIDTH-bit LED pattern register with hold/rotate/bounce stepping and wrap pulse
module light_pattern_gen
   import light_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int TICK_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] dout,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};
   logic             step;
   logic             next_wrap;
   logic [1:0]       prev_mode;
   logic [WIDTH-1:0] next_dout;
   dir_t             dir, eff_dir, next_dir;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (load),
      .step   (step)
   );

   // next pattern, wrap and bounce direction if a step were taken this cycle
   always_comb begin
      eff_dir   = (prev_mode == MODE_BOUNCE) ? dir : DIR_LEFT;
      next_dout = dout;
      next_wrap = 1'b0;
      next_dir  = dir;
      if (&dout) begin
         next_dout = (mode == MODE_HOLD) ? dout : (mode == MODE_ROT_R) ? MSB_ONLY : LSB_ONLY;
         next_dir  = (mode == MODE_BOUNCE) ? DIR_LEFT : dir;
      end else begin
         case (mode)
            MODE_ROT_L: begin
               next_dout = {dout[WIDTH-2:0], dout[WIDTH-1]};
               next_wrap = dout[WIDTH-1];
            end
            MODE_ROT_R: begin
               next_dout = {dout[0], dout[WIDTH-1:1]};
               next_wrap = dout[0];
            end
            MODE_BOUNCE: begin
               next_wrap = (eff_dir == DIR_LEFT) ? dout[WIDTH-1] : dout[0];
               next_dir  = next_wrap ? ((eff_dir == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT) : eff_dir;
               next_dout = (next_dir == DIR_LEFT) ? dout << 1 : dout >> 1;
            end
            default: ;
         endcase
      end
   end

   // pattern state: load beats step, wrap only pulses on the step edge
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         dout      <= '1;
         wrap      <= 1'b0;
         dir       <= DIR_LEFT;
         prev_mode <= MODE_HOLD;
      end else if (load) begin
         dout <= load_value;
         wrap <= 1'b0;
         dir  <= DIR_LEFT;
      end else if (step) begin
         dout      <= next_dout;
         wrap      <= next_wrap;
         dir       <= next_dir;
         prev_mode <= mode;
      end else begin
         wrap <= 1'b0;
      end
endmodule
